seg7_to_bcd_rx: RTL and testbench

SEG7_TO_BCD_RX -- requirements
Module: seg7_to_bcd_rx

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_lookup.sv | 39 +++
 rtl/seg7_to_bcd_rx.sv | 158 +++++++++++++++
 tb/tb_seg7_to_bcd_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Seven-segment code constants and receiver state type.
// Codes are active-low in abcdefg order; bit [0] of a [0:6] vector is segment a.
package seg7_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [0:6] SEG_D0    = 7'b0000001;
  localparam logic [0:6] SEG_D1    = 7'b1001111;
  localparam logic [0:6] SEG_D2    = 7'b0010010;
  localparam logic [0:6] SEG_D3    = 7'b0000110;
  localparam logic [0:6] SEG_D4    = 7'b1001100;
  localparam logic [0:6] SEG_D5    = 7'b0100100;
  localparam logic [0:6] SEG_D6    = 7'b0100000;
  localparam logic [0:6] SEG_D7    = 7'b0001111;
  localparam logic [0:6] SEG_D8    = 7'b0000000;
  localparam logic [0:6] SEG_D9    = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_lookup.sv
// Combinational decode of an active-low seven-segment code.
// Ports:
//   seg     - segment code, abcdefg, seg[0] = a
//   legal_c - code is one of the ten digit patterns
//   blank_c - code is the all-off pattern
//   digit_c - decoded digit value (0 when not legal)
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [0:6]         seg,
  output logic               legal_c,
  output logic               blank_c,
  output logic [DIGIT_W-1:0] digit_c
);

  always_comb begin
    legal_c = 1'b1;
    blank_c = 1'b0;
    digit_c = '0;
    case (seg)
      SEG_D0:    digit_c = 4'd0;
      SEG_D1:    digit_c = 4'd1;
      SEG_D2:    digit_c = 4'd2;
      SEG_D3:    digit_c = 4'd3;
      SEG_D4:    digit_c = 4'd4;
      SEG_D5:    digit_c = 4'd5;
      SEG_D6:    digit_c = 4'd6;
      SEG_D7:    digit_c = 4'd7;
      SEG_D8:    digit_c = 4'd8;
      SEG_D9:    digit_c = 4'd9;
      SEG_BLANK: begin
        legal_c = 1'b0;
        blank_c = 1'b1;
      end
      default:   legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_bcd_rx.sv
// Seven-segment to BCD receiver: debounces sampled segment codes, shifts
// accepted digits into a BCD word and hands the full word to a consumer.
// Ports:
//   CLOCK_50   - clock, rising edge
//   RST        - asynchronous active-high reset
//   SEG_IN     - active-low segment code, abcdefg, SEG_IN[0] = a
//   SEG_VALID  - SEG_IN meaningful this cycle
//   SEG_READY  - receiver is sampling SEG_IN (collecting)
//   BCD_WORD   - assembled digits, most recent in [3:0]
//   WORD_VALID - BCD_WORD complete and held
//   WORD_READY - consumer takes BCD_WORD
//   DIGIT_CNT  - digits collected in the current word
//   ERR        - one-cycle pulse when an illegal code is accepted
module seg7_to_bcd_rx
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned NDIGITS       = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   RST,
  input  logic [0:6]             SEG_IN,
  input  logic                   SEG_VALID,
  output logic                   SEG_READY,
  output logic [4*NDIGITS-1:0]   BCD_WORD,
  output logic                   WORD_VALID,
  input  logic                   WORD_READY,
  output logic [2:0]             DIGIT_CNT,
  output logic                   ERR
);

  localparam int unsigned WORD_W = 4 * NDIGITS;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DCNT_W = 3;

  localparam logic [CNT_W-1:0]  STABLE_N = CNT_W'(STABLE_CYCLES);
  localparam logic [DCNT_W-1:0] FULL_N   = DCNT_W'(NDIGITS);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [0:6]          last_q, last_d;
  logic                armed_q, armed_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                err_q, err_d;
  logic                wvalid_q, wvalid_d;
  logic                sready_q, sready_d;

  logic                legal_c;
  logic                blank_c;
  logic [DIGIT_W-1:0]  digit_c;

  seg7_lookup u_lookup (
    .seg     (SEG_IN),
    .legal_c (legal_c),
    .blank_c (blank_c),
    .digit_c (digit_c)
  );

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      last_q   <= SEG_BLANK;
      armed_q  <= 1'b1;
      word_q   <= '0;
      dcnt_q   <= '0;
      err_q    <= 1'b0;
      wvalid_q <= 1'b0;
      sready_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      armed_q  <= armed_d;
      word_q   <= word_d;
      dcnt_q   <= dcnt_d;
      err_q    <= err_d;
      wvalid_q <= wvalid_d;
      sready_q <= sready_d;
    end
  end

  // Next state: stability filter, digit shift and word handoff
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    armed_d  = armed_q;
    word_d   = word_q;
    dcnt_d   = dcnt_q;
    err_d    = 1'b0;
    wvalid_d = wvalid_q;
    sready_d = sready_q;

    case (state_q)
      COLLECT: begin
        if (!SEG_VALID) begin
          cnt_d   = '0;
          armed_d = 1'b1;
        end else begin
          // A count of zero means no run is in progress, so any code starts one.
          if ((cnt_q == '0) || (SEG_IN != last_q)) begin
            cnt_d   = CNT_W'(1);
            last_d  = SEG_IN;
            armed_d = 1'b1;
          end else if (cnt_q < STABLE_N) begin
            cnt_d = cnt_q + CNT_W'(1);
          end

          // Saturated count plus disarm gives one acceptance per long hold.
          if (armed_d && (cnt_d == STABLE_N)) begin
            armed_d = blank_c;
            if (legal_c) begin
              word_d = WORD_W'({word_q, digit_c});
              dcnt_d = dcnt_q + DCNT_W'(1);
              if (dcnt_d == FULL_N) begin
                state_d  = FULL;
                wvalid_d = 1'b1;
                sready_d = 1'b0;
                cnt_d    = '0;
                armed_d  = 1'b1;
              end
            end else if (!blank_c) begin
              err_d = 1'b1;
            end
          end
        end
      end

      FULL: begin
        cnt_d   = '0;
        armed_d = 1'b1;
        if (WORD_READY) begin
          state_d  = COLLECT;
          word_d   = '0;
          dcnt_d   = '0;
          wvalid_d = 1'b0;
          sready_d = 1'b1;
        end
      end

      default: begin
        state_d  = COLLECT;
        sready_d = 1'b1;
        wvalid_d = 1'b0;
      end
    endcase
  end

  assign SEG_READY  = sready_q;
  assign BCD_WORD   = word_q;
  assign WORD_VALID = wvalid_q;
  assign DIGIT_CNT  = dcnt_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_seg7_to_bcd_rx.sv
// Self-checking bench for seg7_to_bcd_rx: directed scenarios followed by
// random segment streams, compared every cycle against a run-length model.
module tb_seg7_to_bcd_rx;

  localparam int unsigned STABLE = 4;
  localparam int unsigned ND     = 4;

  logic              CLOCK_50 = 1'b0;
  logic              RST;
  logic [0:6]        SEG_IN;
  logic              SEG_VALID;
  logic              SEG_READY;
  logic [4*ND-1:0]   BCD_WORD;
  logic              WORD_VALID;
  logic              WORD_READY;
  logic [2:0]        DIGIT_CNT;
  logic              ERR;

  seg7_to_bcd_rx #(.STABLE_CYCLES(STABLE), .NDIGITS(ND)) dut (
    .CLOCK_50   (CLOCK_50),
    .RST        (RST),
    .SEG_IN     (SEG_IN),
    .SEG_VALID  (SEG_VALID),
    .SEG_READY  (SEG_READY),
    .BCD_WORD   (BCD_WORD),
    .WORD_VALID (WORD_VALID),
    .WORD_READY (WORD_READY),
    .DIGIT_CNT  (DIGIT_CNT),
    .ERR        (ERR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors   = 0;
  int checks   = 0;
  int err_seen = 0;

  // Digit patterns, abcdefg with a in the MSB, 0 = lit.
  logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100};
  localparam logic [6:0] BLANK   = 7'b1111111;
  localparam logic [6:0] ILLEGAL = 7'b1111110;

  // Reference model: length of the current run of identical valid samples,
  // the digits received so far, and whether the word awaits the consumer.
  int         m_run_len;
  logic [6:0] m_run_code;
  int         m_digits[$];
  bit         m_full;
  bit         m_err;

  function automatic int decode(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (c == codes[i]) return i;
    if (c == BLANK) return 10;
    return -1;
  endfunction

  function automatic logic [31:0] exp_word();
    int w = 0;
    foreach (m_digits[i]) w = w * 16 + m_digits[i];
    return 32'(w);
  endfunction

  task automatic model_reset();
    m_run_len = 0;
    m_run_code = BLANK;
    m_digits.delete();
    m_full = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_clock(input logic [6:0] seg, input bit v, input bit wr);
    int d;
    m_err = 1'b0;
    if (m_full) begin
      m_run_len = 0;
      if (wr) begin
        m_full = 1'b0;
        m_digits.delete();
      end
    end else if (!v) begin
      m_run_len = 0;
    end else begin
      if (m_run_len > 0 && seg == m_run_code) m_run_len++;
      else begin
        m_run_code = seg;
        m_run_len  = 1;
      end
      if (m_run_len == STABLE) begin
        d = decode(seg);
        if (d < 0) m_err = 1'b1;
        else if (d < 10) begin
          m_digits.push_back(d);
          if (m_digits.size() == ND) begin
            m_full    = 1'b1;
            m_run_len = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("bcd_word",   32'(BCD_WORD),   exp_word());
    chk("digit_cnt",  32'(DIGIT_CNT),  32'(m_digits.size()));
    chk("word_valid", 32'(WORD_VALID), 32'(m_full));
    chk("seg_ready",  32'(SEG_READY),  32'(!m_full));
    chk("err",        32'(ERR),        32'(m_err));
  endtask

  task automatic step(input logic [6:0] seg, input bit v, input bit wr);
    SEG_IN     = seg;
    SEG_VALID  = v;
    WORD_READY = wr;
    @(posedge CLOCK_50);
    if (RST) model_reset();
    else model_clock(seg, v, wr);
    #1;
    if (ERR === 1'b1) err_seen++;
    check_all();
  endtask

  task automatic hold(input logic [6:0] seg, input int n);
    repeat (n) step(seg, 1'b1, 1'b0);
  endtask

  task automatic gap();
    step(BLANK, 1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges; checked before any edge arrives.
  task automatic mid_reset();
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge CLOCK_50);
    #1;
    check_all();
    RST = 1'b0;
  endtask

  initial begin
    logic [6:0] code;
    int         k;
    int         len;
    bit         v;

    RST        = 1'b1;
    SEG_IN     = BLANK;
    SEG_VALID  = 1'b0;
    WORD_READY = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge CLOCK_50);
    #1;
    check_all();
    RST = 1'b0;

    // Word assembly 2,0,2,2
    hold(codes[2], 4); gap();
    hold(codes[0], 4); gap();
    hold(codes[2], 4); gap();
    hold(codes[2], 4);
    chk("asm_word",  32'(BCD_WORD),   32'h2022);
    chk("asm_valid", 32'(WORD_VALID), 32'd1);
    chk("asm_cnt",   32'(DIGIT_CNT),  32'd4);
    step(BLANK, 1'b0, 1'b1);
    chk("asm_drain_valid", 32'(WORD_VALID), 32'd0);
    chk("asm_drain_word",  32'(BCD_WORD),   32'd0);

    // Short glitch of 7 followed by a long hold of 1
    hold(codes[7], 3);
    hold(codes[1], 9);
    gap();
    chk("glitch_cnt",  32'(DIGIT_CNT), 32'd1);
    chk("glitch_word", 32'(BCD_WORD),  32'h0001);

    // Illegal code
    err_seen = 0;
    hold(ILLEGAL, 4);
    gap();
    chk("illegal_err_pulses", 32'(err_seen),  32'd1);
    chk("illegal_cnt",        32'(DIGIT_CNT), 32'd1);

    // Backpressure with digit 5 driven while full
    hold(codes[3], 4); gap();
    hold(codes[4], 4); gap();
    hold(codes[9], 4);
    repeat (10) step(codes[5], 1'b1, 1'b0);
    chk("bp_word",  32'(BCD_WORD),  32'h1349);
    chk("bp_ready", 32'(SEG_READY), 32'd0);
    chk("bp_cnt",   32'(DIGIT_CNT), 32'd4);
    step(codes[5], 1'b0, 1'b1);
    chk("bp_drain_valid", 32'(WORD_VALID), 32'd0);
    chk("bp_drain_word",  32'(BCD_WORD),   32'd0);
    gap();

    // Reset after two digits, then a fresh word
    hold(codes[6], 4); gap();
    hold(codes[8], 4); gap();
    chk("pre_rst_cnt", 32'(DIGIT_CNT), 32'd2);
    mid_reset();
    chk("rst_cnt",  32'(DIGIT_CNT), 32'd0);
    chk("rst_word", 32'(BCD_WORD),  32'd0);
    hold(codes[1], 4); gap();
    hold(codes[2], 4); gap();
    hold(codes[3], 4); gap();
    hold(codes[4], 4);
    chk("fresh_word",  32'(BCD_WORD),   32'h1234);
    chk("fresh_valid", 32'(WORD_VALID), 32'd1);
    step(BLANK, 1'b0, 1'b1);

    // Random streams of digits, blanks and arbitrary codes
    repeat (150) begin
      k = $urandom_range(0, 11);
      if (k < 10) code = codes[k];
      else if (k == 10) code = BLANK;
      else code = 7'($urandom);
      len = $urandom_range(1, 7);
      v   = ($urandom_range(0, 7) != 0);
      repeat (len) step(code, v, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
